hazard_scoreboard: RTL

//  Next-gen hazard unit: bypass select, load-use/branch stalls, plus a scoreboard for one

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_scoreboard_if.sv | 48 ++++
 rtl/hazard_scoreboard_fwd_sel.sv | 27 ++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and bypass-select encoding for the hazard/scoreboard unit.
package hazard_pkg;

  localparam int REG_SIZE = 5;
  localparam int MAX_LAT  = 16;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    FORWARD_N = 2'b00,
    FORWARD_M = 2'b01,
    FORWARD_W = 2'b10,
    FORWARD_X = 2'b11
  } fwd_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard unit: register tags in, stall/flush/bypass control out.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_SIZE = hazard_pkg::REG_SIZE,
  parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
  parameter int CNT_W    = hazard_pkg::CNT_W
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [REG_SIZE-1:0] raddr1D, raddr2D, raddr1E, raddr2E;
  logic [REG_SIZE-1:0] writeRegD, writeRegE, writeRegM, writeRegW;
  logic                regWriteD, regWriteE, regWriteM, regWriteW;
  logic                mem2regE, mem2regM;
  logic                branchD, controllchangeD;
  logic                mcOpD, mcIssueE;
  logic [REG_SIZE-1:0] writeRegMcE;
  logic [LAT_W-1:0]    mcLatency;

  logic                stallF, stallD, flushE, flushD;
  fwd_e                forward1D, forward2D, forward1E, forward2E;
  logic                mcDone;
  logic [REG_SIZE-1:0] mcWriteReg;
  logic [CNT_W-1:0]    stallCycles;

  modport slave (
    input  raddr1D, raddr2D, raddr1E, raddr2E,
    input  writeRegD, writeRegE, writeRegM, writeRegW,
    input  regWriteD, regWriteE, regWriteM, regWriteW,
    input  mem2regE, mem2regM, branchD, controllchangeD,
    input  mcOpD, mcIssueE, writeRegMcE, mcLatency,
    output stallF, stallD, flushE, flushD,
    output forward1D, forward2D, forward1E, forward2E,
    output mcDone, mcWriteReg, stallCycles
  );

  modport master (
    output raddr1D, raddr2D, raddr1E, raddr2E,
    output writeRegD, writeRegE, writeRegM, writeRegW,
    output regWriteD, regWriteE, regWriteM, regWriteW,
    output mem2regE, mem2regM, branchD, controllchangeD,
    output mcOpD, mcIssueE, writeRegMcE, mcLatency,
    input  stallF, stallD, flushE, flushD,
    input  forward1D, forward2D, forward1E, forward2E,
    input  mcDone, mcWriteReg, stallCycles
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Bypass select for one read port: multicycle result beats M, M beats W; r0 never bypasses.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_SIZE = hazard_pkg::REG_SIZE
) (
  input  logic [REG_SIZE-1:0] raddr,
  input  logic [REG_SIZE-1:0] m_reg,
  input  logic                m_we,
  input  logic [REG_SIZE-1:0] w_reg,
  input  logic                w_we,
  input  logic [REG_SIZE-1:0] x_reg,
  input  logic                x_valid,
  output fwd_e                code
);

  // NOTE: default assigned first so every path writes code; no latch is inferred.
  always_comb begin
    code = FORWARD_N;
    if (raddr != '0) begin
      if (x_valid && raddr == x_reg)   code = FORWARD_X;
      else if (m_we && raddr == m_reg) code = FORWARD_M;
      else if (w_we && raddr == w_reg) code = FORWARD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a one-entry scoreboard for a variable-latency multicycle op.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_SIZE = hazard_pkg::REG_SIZE,
  parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
  parameter int CNT_W    = hazard_pkg::CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic                busy;
  logic [LAT_W-1:0]    cnt;
  logic [REG_SIZE-1:0] mc_dest;
  logic [CNT_W-1:0]    stall_cnt;

  logic             mc_done, mc_pending;
  logic [LAT_W-1:0] lat_m1;
  logic             lw_stall, br_stall, raw_stall, waw_stall, str_stall, stall;

  function automatic logic d_reads(input logic [REG_SIZE-1:0] r,
                                   input logic [REG_SIZE-1:0] a1,
                                   input logic [REG_SIZE-1:0] a2);
    return (r != '0) && (r == a1 || r == a2);
  endfunction

  assign mc_done    = busy && (cnt == '0);
  assign mc_pending = busy && !mc_done;

  // Clamp latency into 1..MAX_LAT; the counter holds cycles remaining after the first.
  always_comb begin
    lat_m1 = hz.mcLatency - LAT_W'(1);
    if (hz.mcLatency == '0)                 lat_m1 = '0;
    else if (hz.mcLatency > LAT_W'(MAX_LAT)) lat_m1 = LAT_W'(MAX_LAT - 1);
  end

  assign lw_stall  = hz.mem2regE && hz.regWriteE && d_reads(hz.writeRegE, hz.raddr1D, hz.raddr2D);
  assign br_stall  = hz.branchD &&
                     ((hz.regWriteE && d_reads(hz.writeRegE, hz.raddr1D, hz.raddr2D)) ||
                      (hz.mem2regM  && d_reads(hz.writeRegM, hz.raddr1D, hz.raddr2D)));
  assign raw_stall = mc_pending && d_reads(mc_dest, hz.raddr1D, hz.raddr2D);
  assign waw_stall = mc_pending && hz.regWriteD && (hz.writeRegD != '0) && (hz.writeRegD == mc_dest);
  assign str_stall = mc_pending && hz.mcOpD;
  assign stall     = lw_stall || br_stall || raw_stall || waw_stall || str_stall;

  assign hz.stallF      = stall;
  assign hz.stallD      = stall;
  assign hz.flushE      = stall;
  assign hz.flushD      = hz.controllchangeD && !stall;
  assign hz.mcDone      = mc_done;
  assign hz.mcWriteReg  = busy ? mc_dest : '0;
  assign hz.stallCycles = stall_cnt;

  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd1d (
    .raddr(hz.raddr1D), .m_reg(hz.writeRegM), .m_we(hz.regWriteM),
    .w_reg(hz.writeRegW), .w_we(hz.regWriteW), .x_reg(mc_dest), .x_valid(mc_done),
    .code(hz.forward1D)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd2d (
    .raddr(hz.raddr2D), .m_reg(hz.writeRegM), .m_we(hz.regWriteM),
    .w_reg(hz.writeRegW), .w_we(hz.regWriteW), .x_reg(mc_dest), .x_valid(mc_done),
    .code(hz.forward2D)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd1e (
    .raddr(hz.raddr1E), .m_reg(hz.writeRegM), .m_we(hz.regWriteM),
    .w_reg(hz.writeRegW), .w_we(hz.regWriteW), .x_reg(mc_dest), .x_valid(mc_done),
    .code(hz.forward1E)
  );
  fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd2e (
    .raddr(hz.raddr2E), .m_reg(hz.writeRegM), .m_we(hz.regWriteM),
    .w_reg(hz.writeRegW), .w_we(hz.regWriteW), .x_reg(mc_dest), .x_valid(mc_done),
    .code(hz.forward2E)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      mc_dest   <= '0;
      stall_cnt <= '0;
    end else begin
      if (hz.mcIssueE) begin
        busy    <= 1'b1;
        mc_dest <= hz.writeRegMcE;
        cnt     <= lat_m1;
      end else if (mc_done) begin
        busy <= 1'b0;
      end else if (busy) begin
        cnt <= cnt - LAT_W'(1);
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  a_issue_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(hz.mcIssueE && mc_pending));
  a_wb_port_clash: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_done && hz.regWriteW && hz.writeRegW == mc_dest && mc_dest != '0));

endmodule
